// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: row sense in, column drive and decoded key out.
// The scanner is the master; the keypad model or pad ring sits on the slave side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] dbg_state;

    // No handshake: key_valid is a level that stays high while the accepted
    // key is held, and key_code is stable for as long as key_valid is high.
    modport master (
        input  row,
        output col,
        output key_valid,
        output key_code,
        output dbg_state
    );

    modport slave (
        output row,
        input  col,
        input  key_valid,
        input  key_code,
        input  dbg_state
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// press and release of a single key, and reports a 4-bit key code.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_e;

    state_e           state_q;
    logic [3:0]       meta_q;
    logic [3:0]       rs_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       ci_q;
    logic [1:0]       ri_q;
    logic [CNT_W-1:0] cnt_q;
    logic             key_valid_q;
    logic [3:0]       key_code_q;

    logic             one_low;
    logic [1:0]       low_idx;
    logic [3:0]       pat;

    function automatic logic [3:0] map_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two or more rows low in one column is a ghost/multi-key and is ignored.
    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (rs_q)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign pat = ~(4'b0001 << ri_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            meta_q      <= 4'hF;
            rs_q        <= 4'hF;
            div_q       <= '0;
            ci_q        <= 2'd0;
            ri_q        <= 2'd0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            meta_q <= kp.row;
            rs_q   <= meta_q;
            case (state_q)
                SCAN: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (one_low) begin
                            ri_q    <= low_idx;
                            cnt_q   <= '0;
                            state_q <= DEB_PRESS;
                        end else begin
                            ci_q <= ci_q + 2'd1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                DEB_PRESS: begin
                    if (rs_q != pat) begin
                        cnt_q   <= '0;
                        ci_q    <= ci_q + 2'd1;
                        state_q <= SCAN;
                    end else if (cnt_q == CNT_LAST) begin
                        key_code_q  <= map_code(ri_q, ci_q);
                        key_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= PRESSED;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // A second key in the frozen column changes rs but is not all-high.
                    if (rs_q == 4'hF) begin
                        cnt_q   <= '0;
                        state_q <= DEB_RELEASE;
                    end
                end
                DEB_RELEASE: begin
                    if (rs_q == 4'hF) begin
                        if (cnt_q == CNT_LAST) begin
                            key_valid_q <= 1'b0;
                            cnt_q       <= '0;
                            ci_q        <= ci_q + 2'd1;
                            state_q     <= SCAN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (rs_q == pat) begin
                        cnt_q   <= '0;
                        state_q <= PRESSED;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.col       = ~(4'b0001 << ci_q);
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model shorts row to column for
// every held key, and each scenario checks key_valid/key_code against hand values.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int LAT = 2 + 4 * SD + DB;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys = '0;

    int checks  = 0;
    int errors  = 0;
    int rises   = 0;
    int falls   = 0;
    int glitch  = 0;
    logic       kv_prev   = 1'b0;
    logic [3:0] code_prev = 4'h0;

    always #5 clk = ~clk;

    keypad_scanner_if kp_bus();

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_bus)
    );

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        kp_bus.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp_bus.col[c]) kp_bus.row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (kp_bus.key_valid && !kv_prev) rises++;
        if (!kp_bus.key_valid && kv_prev) falls++;
        if (kp_bus.key_valid && kv_prev && kp_bus.key_code != code_prev) glitch++;
        kv_prev   = kp_bus.key_valid;
        code_prev = kp_bus.key_code;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // n = clock edges until key_valid reaches lvl; n-1 whole cycles elapsed.
    task automatic wait_kv(input logic lvl, input int budget, output int n);
        n = 0;
        while (kp_bus.key_valid !== lvl && n < budget) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int r0;
        int f0;
        int ncol;
        int kvhi;
        logic [3:0] cprev;
        logic [3:0] exp_col;
        int         seq_idx[5]  = '{0, 1, 2, 4, 14};
        logic [3:0] seq_code[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};

        // Reset state.
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_key_valid", 32'(kp_bus.key_valid), 32'(0));
        chk("rst_key_code",  32'(kp_bus.key_code),  32'(4'h0));
        chk("rst_col",       32'(kp_bus.col),       32'(4'b1110));
        chk("rst_state",     32'(kp_bus.dbg_state), 32'(0));
        step(2);
        rst = 1'b1;

        // Idle scan: each column held SD cycles, wrapping 3 -> 0.
        for (int k = 0; k < 20; k++) begin
            exp_col = ~(4'b0001 << ((k / SD) % 4));
            chk($sformatf("idle_col_%0d", k), 32'(kp_bus.col), 32'(exp_col));
            step(1);
        end
        chk("idle_no_valid", 32'(rises), 32'(0));

        // Key '5' held ~100 cycles with a brief release dropout mid-hold.
        r0 = rises;
        keys[5] = 1'b1;
        wait_kv(1'b1, 40, n);
        chk("k5_rise", 32'(kp_bus.key_valid), 32'(1));
        chk("k5_latency", 32'((n - 1) <= LAT), 32'(1));
        chk("k5_code", 32'(kp_bus.key_code), 32'(4'h5));
        step(30);
        f0 = falls;
        keys[5] = 1'b0;
        step(3);
        keys[5] = 1'b1;
        step(60);
        chk("k5_no_drop", 32'(falls - f0), 32'(0));
        keys[5] = 1'b0;
        wait_kv(1'b0, 30, n);
        chk("k5_fall", 32'(kp_bus.key_valid), 32'(0));
        chk("k5_release_lag", 32'((n - 1) >= 8 && (n - 1) <= 10), 32'(1));
        step(20);
        chk("k5_code_held", 32'(kp_bus.key_code), 32'(4'h5));
        chk("k5_one_pulse", 32'(rises - r0), 32'(1));

        // Key '#' bouncing, then stable.
        r0 = rises;
        for (int i = 0; i < 4; i++) begin
            keys[14] = (i % 2 == 0);
            step(3);
        end
        chk("hash_bounce_quiet", 32'(rises - r0), 32'(0));
        keys[14] = 1'b1;
        wait_kv(1'b1, 40, n);
        chk("hash_rise", 32'(kp_bus.key_valid), 32'(1));
        chk("hash_code", 32'(kp_bus.key_code), 32'(4'hF));
        step(20);
        chk("hash_one_pulse", 32'(rises - r0), 32'(1));
        keys[14] = 1'b0;
        wait_kv(1'b0, 30, n);
        chk("hash_fall", 32'(kp_bus.key_valid), 32'(0));

        // Sequence 1, 2, 3, 4, #, each pressed right after the previous fall.
        r0 = rises;
        glitch = 0;
        for (int i = 0; i < 5; i++) begin
            keys[seq_idx[i]] = 1'b1;
            wait_kv(1'b1, 40, n);
            chk($sformatf("seq%0d_rise", i), 32'(kp_bus.key_valid), 32'(1));
            chk($sformatf("seq%0d_gap", i), 32'((n - 1) >= DB), 32'(1));
            chk($sformatf("seq%0d_code", i), 32'(kp_bus.key_code), 32'(seq_code[i]));
            step(10);
            keys[seq_idx[i]] = 1'b0;
            wait_kv(1'b0, 30, n);
            chk($sformatf("seq%0d_fall", i), 32'(kp_bus.key_valid), 32'(0));
        end
        chk("seq_pulses", 32'(rises - r0), 32'(5));
        chk("seq_code_stable", 32'(glitch), 32'(0));

        // '1' and '4' together: ghost in column 0, scan keeps moving.
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        ncol  = 0;
        kvhi  = 0;
        cprev = kp_bus.col;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (kp_bus.col != cprev) ncol++;
            if (kp_bus.key_valid) kvhi++;
            cprev = kp_bus.col;
        end
        chk("ghost_no_valid", 32'(kvhi), 32'(0));
        chk("ghost_scan_moves", 32'(ncol >= 10), 32'(1));
        keys[0] = 1'b0;
        keys[4] = 1'b0;
        step(5);

        // 'D' held through a reset pulse.
        keys[15] = 1'b1;
        wait_kv(1'b1, 40, n);
        chk("d_rise", 32'(kp_bus.key_valid), 32'(1));
        chk("d_code", 32'(kp_bus.key_code), 32'(4'hD));
        step(5);
        rst = 1'b0;
        #1;
        chk("d_rst_valid", 32'(kp_bus.key_valid), 32'(0));
        chk("d_rst_col", 32'(kp_bus.col), 32'(4'b1110));
        chk("d_rst_code", 32'(kp_bus.key_code), 32'(4'h0));
        step(3);
        rst = 1'b1;
        wait_kv(1'b1, 40, n);
        chk("d_rerise", 32'(kp_bus.key_valid), 32'(1));
        chk("d_recode", 32'(kp_bus.key_code), 32'(4'hD));
        keys[15] = 1'b0;
        wait_kv(1'b0, 30, n);
        chk("d_fall", 32'(kp_bus.key_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column stays driven; legal values are 4 or more.
REQ-002 Parameter DEBOUNCE_CYCLES, default 200000: consecutive stable cycles needed to accept a press or a release; legal values are 2 or more.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  keypad columns, active-low; exactly one bit is low at all times.
REQ-007 key_valid  output  1  level-high while a debounced key is held.
REQ-008 key_code  output  4  code of the last accepted key; stable whenever key_valid is high.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-010 Key map (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D.
REQ-011 Codes: digits map to 4'h0-4'h9, A-D map to 4'hA-4'hD, '*' maps to 4'hE, '#' maps to 4'hF (confirm).
REQ-012 States SHALL be SCAN, DEB_PRESS, PRESSED and DEB_RELEASE.
REQ-013 SCAN: a divider counts 0..SCAN_DIV-1 with column index ci driven (col = ~(1<<ci)).
REQ-014 SCAN: at divider count SCAN_DIV-1, rs is sampled, the divider returns to 0, and the rest of the step is decided by REQ-015 and REQ-016.
REQ-015 SCAN sample with exactly one rs bit low: capture the pattern and ci, clear the debounce counter, go to DEB_PRESS; col stays frozen on ci.
REQ-016 SCAN sample with no bit low, or two or more bits low (ghost/multi-key): ci advances as 3 -> 0 wrap; no other effect.
REQ-017 DEB_PRESS: the counter increments each cycle that rs equals the captured pattern.
REQ-018 DEB_PRESS: any mismatch returns to SCAN with ci advanced by one; key_valid stays 0.
REQ-019 DEB_PRESS: on the edge where the counter reaches DEBOUNCE_CYCLES, key_code loads the mapped code, key_valid becomes 1, the counter clears, and the state goes to PRESSED.
REQ-020 PRESSED: key_valid stays 1 and col stays frozen.
REQ-021 PRESSED: when rs = 4'hF, go to DEB_RELEASE with the counter cleared.
REQ-022 PRESSED: any other pattern change (second key in the same column) is ignored; no new code is issued.
REQ-023 DEB_RELEASE: the counter increments each cycle rs = 4'hF.
REQ-024 DEB_RELEASE: the captured pattern reappearing returns to PRESSED with no key_valid glitch.
REQ-025 DEB_RELEASE: on reaching DEBOUNCE_CYCLES, key_valid goes to 0 and the state goes to SCAN with ci advanced by one.
REQ-026 One press SHALL produce exactly one rising edge of key_valid, regardless of hold time.
REQ-027 key_valid SHALL be low for at least DEBOUNCE_CYCLES cycles between presses.
REQ-028 key_code SHALL hold its value after release until the next accepted press.
REQ-029 Press latency, from a stable row change to key_valid rising, SHALL be at most 2 + 4*SCAN_DIV + DEBOUNCE_CYCLES cycles.

Reset
REQ-030 While rst = 0 (asynchronous): state = SCAN, ci = 0, col = 4'b1110, key_valid = 0, key_code = 4'h0, divider = 0, debounce counter = 0, synchronizer = 4'hF.
REQ-031 Reset asserted mid-press SHALL drop key_valid immediately.
REQ-032 After reset deassertion, a key still held SHALL be re-detected as a new press through the normal scan and debounce path.

Verification (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8, keypad model shorts row to col)
REQ-033 Idle after reset -> col cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles; key_valid stays 0.
REQ-034 Hold key '5' (r1,c1) for 100 cycles, then release -> one key_valid pulse; key_code = 4'h5; key_valid falls 8 to 10 cycles after release.
REQ-035 Key '#' bouncing (4 toggles of 3 cycles) then stable -> no key_valid during the bounce; a single assertion follows with key_code = 4'hF.
REQ-036 Press '1', '2', '3', '4', '#' in sequence -> five key_valid pulses with codes 1, 2, 3, 4, F; each code is stable while key_valid is high.
REQ-037 Press '1' and '4' together (same column, two rows) -> no key_valid; the scan continues.
REQ-038 Press 'D', pulse rst low while key_valid = 1, keep holding -> key_valid = 0 within the reset; it reasserts with code 4'hD after re-debounce.
